// File: rtl/exec_unit_pkg.sv
// Shared CPU types (lib_cpu): pipeline stage, decoded opecode and datapath widths.
// Used by the decoder/execute interface, the execute stage and its adder.
package lib_cpu;

    localparam int DATA_W = 4;
    localparam int PC_W   = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } STAGE;

    typedef enum logic [3:0] {
        ADD_A_IMM = 4'd0,
        ADD_B_IMM = 4'd1,
        MOV_A_IMM = 4'd2,
        MOV_B_IMM = 4'd3,
        MOV_A_B   = 4'd4,
        MOV_B_A   = 4'd5,
        IN_A      = 4'd6,
        IN_B      = 4'd7,
        OUT_B     = 4'd8,
        OUT_IMM   = 4'd9,
        JMP_IMM   = 4'd10,
        JNC_IMM   = 4'd11,
        INVALID   = 4'd12
    } OPECODE;

endpackage

// File: rtl/exec_unit_if.sv
// Decoder <-> execute bus: stage, decoded instruction and the pc fed back to fetch.
// master = decoder side, slave = execute stage.
interface exec_unit_if;
    import lib_cpu::*;

    STAGE   stage;
    OPECODE opecode;
    word_t  imm;
    logic [PC_W-1:0] pc;

    modport master (output stage, output opecode, output imm, input pc);
    modport slave  (input stage, input opecode, input imm, output pc);

endinterface

// File: rtl/exec_unit_alu_add4.sv
// alu_add4: combinational 4-bit unsigned adder with carry-out.
module alu_add4
    import lib_cpu::*;
(
    input  word_t a,
    input  word_t b,
    output word_t sum,
    output logic  cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/exec_unit.sv
// Execute stage of the 4-bit CPU: owns A/B, carry, pc and the output port.
// Optional jump-to-self halt is enabled by defining EXEC_UNIT_HALT_EN.
module exec_unit
    import lib_cpu::*;
#(
    parameter logic [PC_W-1:0]   PC_RESET  = 4'h0,
    parameter logic [DATA_W-1:0] OUT_RESET = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    exec_unit_if.slave  dec,
    input  word_t       in_port,
    output word_t       out_port,
    output word_t       reg_a,
    output word_t       reg_b,
    output logic        carry,
    output logic        illegal,
    output logic        halted
);

    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    word_t reg_a_q, reg_a_d, reg_b_q, reg_b_d, out_q, out_d;
    logic  carry_q, carry_d, illegal_q, illegal_d, halted_q, halted_d;

    word_t add_op, add_sum;
    logic  add_cout, commit;

    assign add_op = (dec.opecode == ADD_B_IMM) ? reg_b_q : reg_a_q;

    alu_add4 u_add (
        .a    (add_op),
        .b    (dec.imm),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign commit = (dec.stage == EXECUTE) && !halted_q;
    assign pc_inc = pc_q + 4'd1;

    always_comb begin
        pc_d      = pc_q;
        reg_a_d   = reg_a_q;
        reg_b_d   = reg_b_q;
        out_d     = out_q;
        carry_d   = carry_q;
        illegal_d = illegal_q;
        halted_d  = halted_q;
        if (commit) begin
            // Non-ADD instructions always clear carry; ADD overrides below.
            carry_d = 1'b0;
            pc_d    = pc_inc;
            case (dec.opecode)
                ADD_A_IMM: begin reg_a_d = add_sum; carry_d = add_cout; end
                ADD_B_IMM: begin reg_b_d = add_sum; carry_d = add_cout; end
                MOV_A_IMM: reg_a_d = dec.imm;
                MOV_B_IMM: reg_b_d = dec.imm;
                MOV_A_B:   reg_a_d = reg_b_q;
                MOV_B_A:   reg_b_d = reg_a_q;
                IN_A:      reg_a_d = in_port;
                IN_B:      reg_b_d = in_port;
                OUT_B:     out_d   = reg_b_q;
                OUT_IMM:   out_d   = dec.imm;
                JMP_IMM: begin
                    pc_d = dec.imm;
`ifdef EXEC_UNIT_HALT_EN
                    if (dec.imm == pc_q) halted_d = 1'b1;
`endif
                end
                JNC_IMM:   if (!carry_q) pc_d = dec.imm;
                default:   illegal_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= PC_RESET;
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            out_q     <= OUT_RESET;
            carry_q   <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            reg_a_q   <= reg_a_d;
            reg_b_q   <= reg_b_d;
            out_q     <= out_d;
            carry_q   <= carry_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    assign dec.pc   = pc_q;
    assign reg_a    = reg_a_q;
    assign reg_b    = reg_b_q;
    assign out_port = out_q;
    assign carry    = carry_q;
    assign illegal  = illegal_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vector table, hand sequences and
// randomized instructions against an arithmetic reference model.
module tb_exec_unit;
    import lib_cpu::*;

`ifdef EXEC_UNIT_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    word_t in_port, out_port, reg_a, reg_b;
    logic carry, illegal, halted;

    exec_unit_if bus ();

    exec_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dec      (bus.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .carry    (carry),
        .illegal  (illegal),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state, plain integers.
    int m_pc, m_a, m_b, m_c, m_out, m_ill, m_halt;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int pc, input int a, input int b,
                           input int c, input int o, input int ill, input int hlt);
        chk({tag, " pc"},      8'(bus.pc),   8'(pc));
        chk({tag, " reg_a"},   8'(reg_a),    8'(a));
        chk({tag, " reg_b"},   8'(reg_b),    8'(b));
        chk({tag, " carry"},   8'(carry),    8'(c));
        chk({tag, " out"},     8'(out_port), 8'(o));
        chk({tag, " illegal"}, 8'(illegal),  8'(ill));
        chk({tag, " halted"},  8'(halted),   8'(hlt));
    endtask

    task automatic model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0; m_ill = 0; m_halt = 0;
    endtask

    task automatic model_commit(input OPECODE op, input int imm, input int inp);
        int s, npc, nc;
        npc = (m_pc + 1) % 16;
        nc  = 0;
        case (op)
            ADD_A_IMM: begin s = m_a + imm; m_a = s % 16; nc = s / 16; end
            ADD_B_IMM: begin s = m_b + imm; m_b = s % 16; nc = s / 16; end
            MOV_A_IMM: m_a = imm;
            MOV_B_IMM: m_b = imm;
            MOV_A_B:   m_a = m_b;
            MOV_B_A:   m_b = m_a;
            IN_A:      m_a = inp;
            IN_B:      m_b = inp;
            OUT_B:     m_out = m_b;
            OUT_IMM:   m_out = imm;
            JMP_IMM: begin
                if (HALT_EN && imm == m_pc) m_halt = 1;
                npc = imm;
            end
            JNC_IMM:   if (m_c == 0) npc = imm;
            default:   m_ill = 1;
        endcase
        m_c  = nc;
        m_pc = npc;
    endtask

    // Called at a negedge: drive, take one rising edge, return at the next negedge.
    task automatic step(input STAGE st, input OPECODE op, input int imm, input int inp);
        bus.stage   = st;
        bus.opecode = op;
        bus.imm     = 4'(imm);
        in_port     = 4'(inp);
        @(posedge clk);
        if (rst_n && st == EXECUTE && m_halt == 0) model_commit(op, imm, inp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(EXECUTE, MOV_A_IMM, 5, 0);
        step(EXECUTE, MOV_A_IMM, 5, 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        OPECODE op;
        int imm, inp;
        int pc, a, b, c, o, ill;
    } vec_t;

    vec_t vt[15];

    initial begin
        vt[0]  = '{MOV_A_IMM, 'hE, 0,   1, 'hE, 0,   0, 0,   0};
        vt[1]  = '{ADD_A_IMM, 3,   0,   2, 1,   0,   1, 0,   0};
        vt[2]  = '{MOV_B_A,   0,   0,   3, 1,   1,   0, 0,   0};
        vt[3]  = '{ADD_A_IMM, 'hF, 0,   4, 0,   1,   1, 0,   0};
        vt[4]  = '{JNC_IMM,   9,   0,   5, 0,   1,   0, 0,   0};
        vt[5]  = '{JNC_IMM,   9,   0,   9, 0,   1,   0, 0,   0};
        vt[6]  = '{IN_B,      0,   'hA, 10, 0,  'hA, 0, 0,   0};
        vt[7]  = '{OUT_B,     0,   0,   11, 0,  'hA, 0, 'hA, 0};
        vt[8]  = '{OUT_IMM,   3,   0,   12, 0,  'hA, 0, 3,   0};
        vt[9]  = '{JMP_IMM,   'hF, 0,   15, 0,  'hA, 0, 3,   0};
        vt[10] = '{INVALID,   7,   0,   0,  0,  'hA, 0, 3,   1};
        vt[11] = '{MOV_B_IMM, 6,   0,   1,  0,  6,   0, 3,   1};
        vt[12] = '{ADD_B_IMM, 2,   0,   2,  0,  8,   0, 3,   1};
        vt[13] = '{IN_A,      0,   5,   3,  5,  8,   0, 3,   1};
        vt[14] = '{MOV_A_B,   0,   0,   4,  8,  8,   0, 3,   1};

        rst_n = 1'b0;
        bus.stage = FETCH; bus.opecode = INVALID; bus.imm = '0; in_port = '0;
        model_reset();
        @(negedge clk);

        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            step(EXECUTE, vt[i].op, vt[i].imm, vt[i].inp);
            chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].a, vt[i].b,
                    vt[i].c, vt[i].o, vt[i].ill, 0);
        end

        // pc = 4 here: jump-to-self, then keep issuing EXECUTE cycles.
        step(EXECUTE, JMP_IMM, 4, 0);
        for (int i = 0; i < 10; i++) begin
            step(EXECUTE, (HALT_EN ? OUT_IMM : JMP_IMM), (HALT_EN ? 9 : 4), 0);
            chk($sformatf("halt pc%0d", i), 8'(bus.pc), 8'd4);
            chk($sformatf("halt flag%0d", i), 8'(halted), 8'(HALT_EN));
            chk($sformatf("halt out%0d", i), 8'(out_port), 8'd3);
        end

        // Non-EXECUTE stages must hold everything.
        do_reset();
        step(EXECUTE, OUT_IMM, 6, 0);
        for (int i = 0; i < 3; i++) begin
            step((i == 1) ? DECODE : FETCH, OUT_IMM, 'hF, 'hF);
            chk_all($sformatf("hold%0d", i), 1, 0, 0, 0, 6, 0, 0);
        end

        // Reset asserted during an EXECUTE cycle discards that instruction.
        step(EXECUTE, ADD_A_IMM, 'hF, 0);
        rst_n = 1'b0;
        step(EXECUTE, ADD_A_IMM, 'hF, 0);
        rst_n = 1'b1;
        model_reset();
        chk_all("rst_exec", 0, 0, 0, 0, 0, 0, 0);

        // Randomized instructions against the model.
        for (int i = 0; i < 400; i++) begin
            STAGE st;
            OPECODE op;
            st = ($urandom_range(0, 99) < 60) ? EXECUTE : STAGE'($urandom_range(0, 3));
            op = OPECODE'($urandom_range(0, 12));
            if (op == INVALID && $urandom_range(0, 3) != 0) op = MOV_A_IMM;
            step(st, op, $urandom_range(0, 15), $urandom_range(0, 15));
            chk_all($sformatf("rnd%0d", i), m_pc, m_a, m_b, m_c, m_out, m_ill, m_halt);
            if (m_halt != 0 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage of the 4-bit CPU, directly downstream of the instruction decoder.
- Consumes the decoded OPECODE plus 4-bit immediate and owns the architectural state: registers A/B, carry flag, program counter, output port.
- Commits all state changes on the clock edge at which stage == EXECUTE.
- Drives pc back to the fetch/ROM side, and out_port to the board.

Parameters:
- PC_RESET, 4'h0, program counter value after reset.
- OUT_RESET, 4'h0, out_port value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- stage  input  STAGE  current pipeline stage; state commits only when EXECUTE.
- opecode  input  OPECODE  decoded instruction from the decoder.
- imm  input  4  immediate field from the decoder.
- in_port  input  4  board input switches.
- pc  output  4  program counter, addresses instruction ROM.
- out_port  output  4  registered board output (LEDs).
- reg_a  output  4  register A (debug/observe).
- reg_b  output  4  register B (debug/observe).
- carry  output  1  carry flag.
- illegal  output  1  sticky flag: an INVALID opecode was executed.
- halted  output  1  halt indication (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous, active-low, fixed.
  - Sampled on clk rising edge with rst_n == 0.
  - Values after reset: pc = PC_RESET, out_port = OUT_RESET, reg_a = 0, reg_b = 0, carry = 0, illegal = 0, halted = 0.
  - Reset has priority over everything, including a reset asserted during an EXECUTE cycle (that instruction is discarded).
- Commit timing:
  - On a rising edge with rst_n == 1 and stage == EXECUTE, exactly one instruction commits.
  - In all other stages every register holds.
  - Results are visible on the outputs the cycle after the EXECUTE cycle.
  - opecode and imm are stable throughout EXECUTE, because the decoder holds them outside DECODE.
- Per-opecode effect:
  - ADD_A_IMM: {carry, reg_a} <= reg_a + imm (5-bit sum; carry = bit 4).
  - ADD_B_IMM: {carry, reg_b} <= reg_b + imm.
  - MOV_A_IMM: reg_a <= imm. MOV_B_IMM: reg_b <= imm.
  - MOV_A_B: reg_a <= reg_b. MOV_B_A: reg_b <= reg_a.
  - IN_A: reg_a <= in_port. IN_B: reg_b <= in_port (sampled at the commit edge).
  - OUT_B: out_port <= reg_b. OUT_IMM: out_port <= imm.
  - JMP_IMM: pc <= imm.
  - JNC_IMM: pc <= imm if carry == 0, else pc + 1. Uses the carry left by the previous instruction.
  - INVALID: no register or port change; illegal <= 1 (sticky until reset).
- Carry rule:
  - Every committed non-ADD instruction, including JNC_IMM and INVALID, clears carry to 0.
  - ADD with sum < 16 also leaves carry 0.
- PC rule:
  - Every committed instruction other than a taken jump does pc <= pc + 1, modulo 16.
  - pc 15 wraps to 0 with no flag.
- All arithmetic is unsigned 4-bit. There are no other flags.

Optional Feature:
- Macro: EXEC_UNIT_HALT_EN.
- Defined:
  - A committed JMP_IMM with imm == pc (jump-to-self) sets halted = 1.
  - While halted, all state freezes regardless of stage.
  - Only reset clears halted.
- Not defined:
  - halted is tied to 0.
  - Jump-to-self executes as an ordinary jump and loops forever.

Decomposition:
- lib_cpu package holds:
  - STAGE and OPECODE, the existing shared types.
  - New constants DATA_W = 4 and PC_W = 4.
  - New typedef word_t = logic[DATA_W-1:0].
- One sub-module, alu_add4: combinational 4-bit + 4-bit adder producing a 4-bit sum and a carry-out; instantiated once.
- Operand mux (A/B) and the commit logic stay in exec_unit.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles while stage == EXECUTE with MOV_A_IMM imm = 5 -> pc = 0, reg_a = 0, out_port = 0, carry = 0, illegal = 0.
- Add with overflow: MOV_A_IMM 0xE, then ADD_A_IMM 0x3 -> reg_a = 0x1, carry = 1, pc = 2. Then MOV_B_A -> reg_b = 0x1, carry = 0.
- Conditional jump: ADD_A_IMM producing carry = 1, then JNC_IMM 0x9 -> pc = previous + 1 (not taken). Repeat with carry = 0 -> pc = 9.
- I/O: in_port = 0xA, IN_B, then OUT_B -> out_port = 0xA. Then OUT_IMM 0x3 -> out_port = 0x3. Holding stage != EXECUTE for 3 cycles -> no output change.
- Wrap and invalid: pc = 15 with INVALID -> pc = 0, illegal = 1, carry = 0, registers unchanged. illegal stays 1 after further valid instructions.
- Halt (EXEC_UNIT_HALT_EN defined): pc = 4, JMP_IMM 4 -> halted = 1, pc frozen at 4 across 10 EXECUTE cycles. Without the macro -> halted = 0 and pc = 4 each cycle.
